// File: rtl/shift_right_serializer.sv
// Parallel-in, serial-out right shifter: emits a WIDTH-bit word LSB chunk first, SHIFT bits per beat.
// Define SHIFT_RIGHT_SERIALIZER_BACK_TO_BACK_EN to accept the next word on the last-beat handshake.
module shift_right_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   SHIFT     = 1,
    parameter logic PAD_VALUE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_valid,
    output logic [SHIFT-1:0] serial_data,
    output logic             serial_last,
    input  logic             serial_ready,
    output logic             busy
);

    localparam int BEATS = (WIDTH + SHIFT - 1) / SHIFT;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFTING
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] beat_count_reg;
    logic             serial_valid_reg;
    logic             serial_last_reg;
    logic             load_fire;
    logic             beat_fire;

    // Bits shifted past the top of the word are replaced by the pad value, so a
    // partial final beat automatically reads PAD_VALUE in its upper bits.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi + SHIFT < WIDTH) begin : g_take
                assign shift_next[gi] = shift_reg[gi + SHIFT];
            end else begin : g_pad
                assign shift_next[gi] = PAD_VALUE;
            end
        end
    endgenerate

`ifdef SHIFT_RIGHT_SERIALIZER_BACK_TO_BACK_EN
    assign load_ready = (state_reg == IDLE) || (serial_last_reg && serial_ready);
`else
    assign load_ready = (state_reg == IDLE);
`endif

    assign load_fire    = load_valid && load_ready;
    assign beat_fire    = serial_valid_reg && serial_ready;
    assign serial_valid = serial_valid_reg;
    assign serial_last  = serial_last_reg;
    assign serial_data  = shift_reg[SHIFT-1:0];
    assign busy         = serial_valid_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            shift_reg        <= {WIDTH{PAD_VALUE}};
            beat_count_reg   <= '0;
            serial_valid_reg <= 1'b0;
            serial_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_fire) begin
                        state_reg        <= SHIFTING;
                        shift_reg        <= load_data;
                        beat_count_reg   <= LAST_COUNT;
                        serial_valid_reg <= 1'b1;
                        serial_last_reg  <= (BEATS == 1);
                    end
                end
                SHIFTING: begin
                    if (beat_fire) begin
                        if (beat_count_reg != '0) begin
                            shift_reg       <= shift_next;
                            beat_count_reg  <= beat_count_reg - ONE_COUNT;
                            serial_last_reg <= (beat_count_reg == ONE_COUNT);
                        end else if (load_fire) begin
                            // Next word replaces the finished one with no idle bubble.
                            shift_reg       <= load_data;
                            beat_count_reg  <= LAST_COUNT;
                            serial_last_reg <= (BEATS == 1);
                        end else begin
                            state_reg        <= IDLE;
                            serial_valid_reg <= 1'b0;
                            serial_last_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg        <= IDLE;
                    serial_valid_reg <= 1'b0;
                    serial_last_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_serializer.sv
// Scoreboard bench for shift_right_serializer: five configurations, directed words with
// hand-computed beats queued at issue time and checked by an independent monitor.
module tb_shift_right_serializer;

    localparam int NI = 5;

    function automatic int cfg_w(input int k);
        case (k)
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_s(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            4:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic logic cfg_p(input int k);
        return (k == 1);
    endfunction

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] lv, lr, sv, sl, sr, bsy;
    logic [7:0]    ld [NI];
    logic [7:0]    sd [NI];

    logic [8:0]    exp_q [NI][$];
    logic [NI-1:0] stall_prev;
    logic [7:0]    held_d [NI];
    logic          held_l [NI];
    int            hs_count [NI];
    int            gap_count;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int   W = cfg_w(gi);
            localparam int   S = cfg_s(gi);
            localparam logic P = cfg_p(gi);
            logic [W-1:0] ld_w;
            logic [S-1:0] sd_w;
            assign ld_w   = ld[gi][W-1:0];
            assign sd[gi] = 8'(sd_w);
            shift_right_serializer #(.WIDTH(W), .SHIFT(S), .PAD_VALUE(P)) dut (
                .clock       (clk),
                .reset       (reset),
                .load_valid  (lv[gi]),
                .load_data   (ld_w),
                .load_ready  (lr[gi]),
                .serial_valid(sv[gi]),
                .serial_data (sd_w),
                .serial_last (sl[gi]),
                .serial_ready(sr[gi]),
                .busy        (bsy[gi])
            );
        end
    endgenerate

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops one expected beat per handshake, checks hold-under-stall.
    initial begin
        stall_prev = '0;
        gap_count  = 0;
        for (int k = 0; k < NI; k++) hs_count[k] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = '0;
            end else begin
                for (int k = 0; k < NI; k++) begin
                    if (stall_prev[k]) begin
                        checks++;
                        if (!sv[k]) begin
                            errors++;
                            $display("FAIL hold_valid[%0d]: valid dropped without handshake", k);
                        end else if (sd[k] != held_d[k] || sl[k] != held_l[k]) begin
                            errors++;
                            $display("FAIL hold_data[%0d]: got d=%0h l=%0b expected d=%0h l=%0b",
                                     k, sd[k], sl[k], held_d[k], held_l[k]);
                        end
                    end
                    if (sv[k]) begin
                        check($sformatf("busy[%0d]", k), int'(bsy[k]), 1);
                        if (sr[k]) begin
                            checks++;
                            if (exp_q[k].size() == 0) begin
                                errors++;
                                $display("FAIL beat[%0d]: unexpected beat d=%0h l=%0b", k, sd[k], sl[k]);
                            end else begin
                                logic [8:0] e;
                                e = exp_q[k].pop_front();
                                if ({sl[k], sd[k]} != e) begin
                                    errors++;
                                    $display("FAIL beat[%0d]: got d=%0h l=%0b expected d=%0h l=%0b",
                                             k, sd[k], sl[k], e[7:0], e[8]);
                                end
                            end
                            hs_count[k]++;
                            stall_prev[k] = 1'b0;
                        end else begin
                            check($sformatf("load_ready_stall[%0d]", k), int'(lr[k]), 0);
                            stall_prev[k] = 1'b1;
                            held_d[k]     = sd[k];
                            held_l[k]     = sl[k];
                        end
                    end else begin
                        stall_prev[k] = 1'b0;
                        if (k == 3 && hs_count[3] > 0 && hs_count[3] < 4) gap_count++;
                    end
                end
            end
        end
    end

    task automatic push(input int k, input logic [7:0] d, input logic last);
        exp_q[k].push_back({last, d});
    endtask

    task automatic load_word(input int k, input logic [7:0] d);
        logic acc;
        acc   = 1'b0;
        ld[k] = d;
        lv[k] = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = lr[k];
            @(posedge clk);
            #1;
        end
        lv[k] = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL load_timeout[%0d]: load_ready never seen", k);
        end
    endtask

    task automatic wait_idle(input int k);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = !sv[k] && (exp_q[k].size() == 0);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout[%0d]: %0d beats still pending", k, exp_q[k].size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        reset = 1'b1;
        lv    = '0;
        sr    = '0;
        for (int k = 0; k < NI; k++) ld[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of every instance
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check($sformatf("reset_state[%0d] {valid,ready,last,busy}", k),
                  int'({sv[k], lr[k], sl[k], bsy[k]}), 4'b0100);
        @(posedge clk);
        #1;

        // W8 S1: 8'b1011_0010 emitted LSB first, then one idle cycle
        sr[0] = 1'b1;
        push(0, 8'd0, 0); push(0, 8'd1, 0); push(0, 8'd0, 0); push(0, 8'd0, 0);
        push(0, 8'd1, 0); push(0, 8'd1, 0); push(0, 8'd0, 0); push(0, 8'd1, 1);
        load_word(0, 8'b1011_0010);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("idle_after_word valid", int'(sv[0]), 0);
        check("idle_after_word load_ready", int'(lr[0]), 1);
        check("queue_drained[0]", exp_q[0].size(), 0);
        @(posedge clk);
        #1;

        // W8 S3 pad 1: 8'hA5 -> 101, 100, 110
        sr[1] = 1'b1;
        push(1, 8'd5, 0); push(1, 8'd4, 0); push(1, 8'd6, 1);
        load_word(1, 8'hA5);
        wait_idle(1);

        // W8 S2 backpressure: 8'hC3 with ready pattern 1,0,0,1,0,1,1
        hs_count[2] = 0;
        sr[2] = 1'b0;
        push(2, 8'd3, 0); push(2, 8'd0, 0); push(2, 8'd0, 0); push(2, 8'd3, 1);
        load_word(2, 8'hC3);
        begin
            logic [6:0] pat;
            pat = 7'b1101001;
            for (int i = 0; i < 7; i++) begin
                sr[2] = pat[i];
                @(posedge clk);
                #1;
            end
        end
        sr[2] = 1'b0;
        @(negedge clk);
        check("backpressure handshakes", hs_count[2], 4);
        check("backpressure idle valid", int'(sv[2]), 0);
        @(posedge clk);
        #1;

        // Reset mid-word after 2 of 8 beats, then 8'hFF
        sr[0] = 1'b0;
        push(0, 8'd0, 0); push(0, 8'd1, 0);
        load_word(0, 8'b1011_0010);
        sr[0] = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        sr[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset {valid,busy,ready,last}", int'({sv[0], bsy[0], lr[0], sl[0]}), 4'b0010);
        @(posedge clk);
        #1;
        sr[0] = 1'b1;
        for (int i = 0; i < 8; i++) push(0, 8'd1, i == 7);
        load_word(0, 8'hFF);
        wait_idle(0);

        // W4 S2 consecutive words 4'h9 then 4'h6
        hs_count[3] = 0;
        gap_count   = 0;
        sr[3] = 1'b1;
        push(3, 8'd1, 0); push(3, 8'd2, 1); push(3, 8'd2, 0); push(3, 8'd1, 1);
        load_word(3, 8'h09);
        load_word(3, 8'h06);
        wait_idle(3);
        check("b2b handshakes", hs_count[3], 4);
`ifdef SHIFT_RIGHT_SERIALIZER_BACK_TO_BACK_EN
        check("b2b valid gap", gap_count, 0);
`else
        check("b2b valid gap", gap_count, 1);
`endif

        // SHIFT == WIDTH: each beat is the whole word and is always last
        sr[4] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            push(4, w, 1);
            load_word(4, w);
        end
        wait_idle(4);

        for (int k = 0; k < NI; k++)
            check($sformatf("final_queue[%0d]", k), exp_q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_right_serializer.md
Name: shift_right_serializer

Overview:
- Parallel-in, serial-out register that shifts right by SHIFT bits per output beat. A WIDTH-bit word is emitted LSB-chunk first.
- Vacated MSBs are filled with PAD_VALUE, the right-shift counterpart of the static left shifter.
- Sits between a parallel producer and a narrow serial link. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, width of the parallel word (>=1).
- SHIFT, 1, bits emitted per beat and shift amount per beat (1..WIDTH).
- PAD_VALUE, 1'b0, bit value shifted into the MSBs and used for padding in a partial last beat.

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  parallel word available.
- load_data  input  WIDTH  parallel word.
- load_ready  output  1  serializer can accept a word.
- serial_valid  output  1  serial beat available.
- serial_data  output  SHIFT  current beat: shift_reg[SHIFT-1:0].
- serial_last  output  1  current beat is the final beat of the word.
- serial_ready  input  1  consumer accepts the beat.
- busy  output  1  word in flight (equal to serial_valid).

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high.
  - Reset values: state=IDLE, shift_reg=all PAD_VALUE, beat_count=0, serial_valid=0, serial_last=0, busy=0, load_ready=1 from the first cycle after reset.
- Beat count: BEATS = ceil(WIDTH/SHIFT). The counter is $clog2(BEATS+1) bits wide.
- States: IDLE and SHIFTING.
- IDLE:
  - load_ready=1, serial_valid=0.
  - load_valid=1 captures load_data into shift_reg and sets beat_count=BEATS-1 → SHIFTING.
  - serial_valid is asserted from the next cycle. Load-to-first-beat latency is 1 cycle.
- SHIFTING:
  - serial_valid=1. serial_data=shift_reg[SHIFT-1:0]. serial_last=(beat_count==0).
  - On serial_valid&&serial_ready with beat_count!=0:
    - shift_reg <= {SHIFT{PAD_VALUE}} concatenated above shift_reg[WIDTH-1:SHIFT].
    - beat_count decrements.
  - On a handshake of the last beat: → IDLE (see the optional feature for the back-to-back exception).
- Backpressure: while serial_ready=0, serial_data, serial_last and shift_reg hold stable. serial_valid never deasserts without a handshake.
- Partial last beat (WIDTH%SHIFT!=0): the upper SHIFT-(WIDTH%SHIFT) bits of the final beat read PAD_VALUE.
- SHIFT==WIDTH: BEATS=1. Every beat has serial_last=1 and serial_data=load_data.
- Load handshake: load_data is ignored while load_ready=0 and is never captured twice.
- Reset mid-word: synchronous reset discards the partial word. Outputs return to reset values the following cycle, with no residual beat.
- Output timing: all outputs are registered or derived from state only, with no combinational path from load_valid to serial_*.

Optional Feature:
- Macro: SHIFT_RIGHT_SERIALIZER_BACK_TO_BACK_EN.
- Defined:
  - load_ready = (state==IDLE) || (serial_last && serial_ready).
  - A load coinciding with the last-beat handshake reloads shift_reg and beat_count and stays in SHIFTING.
  - Result: continuous serial_valid, zero bubble between words.
  - This adds a combinational path serial_ready→load_ready.
- Undefined:
  - load_ready = (state==IDLE) only.
  - Each word is followed by one IDLE cycle with serial_valid=0.
  - Throughput is BEATS+1 cycles per word.

Test Plan:
- WIDTH=8, SHIFT=1, PAD=0, load 8'b1011_0010, serial_ready=1 → 8 beats: serial_data 0,1,0,0,1,1,0,1. serial_last only on beat 8. Then one IDLE cycle with load_ready=1 (feature off).
- WIDTH=8, SHIFT=3, PAD=1, load 8'hA5 → 3 beats: 3'b101, 3'b100, 3'b110 (bits 7:6 =2'b10 plus pad 1 in MSB). serial_last on beat 3.
- Backpressure: WIDTH=8, SHIFT=2, load 8'hC3, serial_ready toggled 1,0,0,1,0,1,1 → beats 2'b11,2'b00,2'b00,2'b11 are each held stable while stalled. Exactly 4 handshakes. load_ready=0 throughout.
- Reset mid-word: after 2 of 8 beats assert reset one cycle → next cycle serial_valid=0, busy=0, load_ready=1. The next load 8'hFF emits eight 1s.
- Back-to-back (macro defined): WIDTH=4, SHIFT=2, load_valid held high with words 4'h9 then 4'h6 → beats 2'b01,2'b10,2'b10,2'b01 on consecutive cycles with no serial_valid gap. Macro undefined → a 1-cycle gap appears after beat 2.
- SHIFT==WIDTH=8, stream of 16 random words with serial_ready=1 → each serial_data equals its load_data and serial_last=1 on every beat. Scoreboard matches in order.
